// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants for the ripple-carry adder datapath.
//   DEFAULT_WIDTH   default operand/sum width
//   MIN_WIDTH/MAX_WIDTH  legal range of the WIDTH parameter
package full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned MIN_WIDTH     = 1;
  localparam int unsigned MAX_WIDTH     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_if.sv
// full_adder_if: operand/result bundle of the registered adder.
//   a, b   WIDTH-bit operands       (master -> slave)
//   c_in   carry-in                 (master -> slave)
//   suma   WIDTH-bit registered sum (slave -> master)
//   carry  registered carry-out     (slave -> master)
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] suma;
  logic             carry;

  modport master (
    output a,
    output b,
    output c_in,
    input  suma,
    input  carry
  );

  modport slave (
    input  a,
    input  b,
    input  c_in,
    output suma,
    output carry
  );

endinterface : full_adder_if

// File: rtl/full_adder_fa_cell.sv
// fa_cell: purely combinational 1-bit full adder.
//   a, b  operand bits
//   ci    carry-in
//   s     sum bit  (a ^ b ^ ci)
//   co    carry-out (majority of a, b, ci)
module fa_cell (
  output logic co,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic ci
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : fa_cell

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with registered outputs.
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears suma and carry)
//   bus.a/b     operands, bus.c_in carry-in (sampled every edge)
//   bus.suma    low WIDTH bits of a+b+c_in, one clock after sampling
//   bus.carry   carry-out of the same addition
// The WIDTH parameter must match the WIDTH of the connected interface.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  logic [WIDTH:0]   c_chain;
  logic [WIDTH-1:0] s_comb;

  assign c_chain[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .co (c_chain[i+1]),
      .s  (s_comb[i]),
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c_chain[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.suma  <= '0;
      bus.carry <= 1'b0;
    end else begin
      bus.suma  <= s_comb;
      bus.carry <= c_chain[WIDTH];
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of full_adder at WIDTH = 1, 8 and 16.
module tb_full_adder;

  logic clk;
  logic rst;

  int unsigned n_tests;
  int unsigned n_fail;

  full_adder_if #(.WIDTH(1))  bus1  ();
  full_adder_if #(.WIDTH(8))  bus8  ();
  full_adder_if #(.WIDTH(16)) bus16 ();

  full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  full_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {carry, suma}, zero-extended to 17 bits.
  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [2:0] abc);
    bus1.a    = abc[2];
    bus1.b    = abc[1];
    bus1.c_in = abc[0];
  endtask

  task automatic drive16_rand(output logic [16:0] exp);
    logic [15:0] ra, rb;
    logic        rc;
    ra = 16'($urandom);
    rb = 16'($urandom);
    rc = 1'($urandom);
    bus16.a    = ra;
    bus16.b    = rb;
    bus16.c_in = rc;
    exp = 17'(ra) + 17'(rb) + 17'(rc);
  endtask

  logic [2:0]  vec   [8];
  logic [1:0]  res   [8];
  logic [16:0] exp16;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // truth table as {a,b,c_in} -> {carry,suma}
    vec[0] = 3'b000; res[0] = 2'b00;
    vec[1] = 3'b010; res[1] = 2'b01;
    vec[2] = 3'b100; res[2] = 2'b01;
    vec[3] = 3'b110; res[3] = 2'b10;
    vec[4] = 3'b001; res[4] = 2'b01;
    vec[5] = 3'b101; res[5] = 2'b10;
    vec[6] = 3'b011; res[6] = 2'b10;
    vec[7] = 3'b111; res[7] = 2'b11;

    // Reset with all-ones inputs, held for two edges.
    rst = 1'b1;
    drive1(3'b111);
    bus8.a  = 8'hFF; bus8.b  = 8'hFF; bus8.c_in  = 1'b1;
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.c_in = 1'b1;
    for (int e = 0; e < 2; e++) begin
      step();
      check("reset_w1",  17'({bus1.carry,  bus1.suma}),  17'h0);
      check("reset_w8",  17'({bus8.carry,  bus8.suma}),  17'h0);
      check("reset_w16", 17'({bus16.carry, bus16.suma}), 17'h0);
    end
    rst = 1'b0;

    // Exhaustive 1-bit truth table.
    for (int i = 0; i < 8; i++) begin
      drive1(vec[i]);
      step();
      check($sformatf("tt_w1_%b", vec[i]), 17'({bus1.carry, bus1.suma}), 17'(res[i]));
    end

    // Latency: change 000 -> 111 mid-cycle, output follows only at the next edge.
    drive1(3'b000);
    step();
    check("lat_base", 17'({bus1.carry, bus1.suma}), 17'h0);
    @(negedge clk);
    drive1(3'b111);
    #1;
    check("lat_hold", 17'({bus1.carry, bus1.suma}), 17'h0);
    step();
    check("lat_edge", 17'({bus1.carry, bus1.suma}), 17'h3);

    // WIDTH=8 boundaries.
    bus8.a = 8'hFF; bus8.b = 8'h00; bus8.c_in = 1'b1;
    step();
    check("w8_ff_00_1", 17'({bus8.carry, bus8.suma}), 17'h100);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c_in = 1'b1;
    step();
    check("w8_ff_ff_1", 17'({bus8.carry, bus8.suma}), 17'h1FF);
    bus8.a = 8'h5A; bus8.b = 8'hA5; bus8.c_in = 1'b0;
    step();
    check("w8_5a_a5_0", 17'({bus8.carry, bus8.suma}), 17'h0FF);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.c_in = 1'b0;
    step();
    check("w8_80_80_0", 17'({bus8.carry, bus8.suma}), 17'h100);

    // Reset during a random stream on WIDTH=16.
    for (int i = 0; i < 4; i++) begin
      drive16_rand(exp16);
      step();
      check("pre_rst_w16", 17'({bus16.carry, bus16.suma}), exp16);
    end
    drive16_rand(exp16);
    rst = 1'b1;
    step();
    check("mid_rst_w16", 17'({bus16.carry, bus16.suma}), 17'h0);
    rst = 1'b0;
    drive16_rand(exp16);
    step();
    check("post_rst_w16", 17'({bus16.carry, bus16.suma}), exp16);

    // WIDTH=16 maximum case.
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.c_in = 1'b1;
    step();
    check("w16_max", 17'({bus16.carry, bus16.suma}), 17'h1FFFF);

    // Random regression, one new vector per clock.
    for (int i = 0; i < 1000; i++) begin
      drive16_rand(exp16);
      step();
      check("rand_w16", 17'({bus16.carry, bus16.suma}), exp16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_full_adder
